mem_reader: RTL and testbench
=============================

Name: mem_reader

Overview:
- Read-side counterpart of the Julia pixel write controller.
- Avalon-MM style read master that fetches one frame of 8-bit Julia pixels from the framebuffer, starting at BASE_ADDR.
- Buffers returned pixels in an internal FIFO and presents them on a valid/ready stream to the display/scan-out logic.
- Supports pipelined reads. Outstanding requests are throttled so returned data never overflows the FIFO.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of pixel 0.
- FRAME_PIXELS, 307200, pixels per frame (640x480); must be >= 1.
- FIFO_DEPTH, 16, pixel FIFO entries; power of two, >= 4.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a frame fetch when idle.
- wait_request  input  1  memory stall; request not accepted while high.
- read_data  input  8  returned pixel.
- read_data_valid  input  1  read_data valid this cycle; returns arrive in request order.
- read_address  output  32  byte address of current request.
- read_enable  output  1  read request.
- pix_data  output  8  FIFO head pixel.
- pix_valid  output  1  FIFO non-empty.
- pix_ready  input  1  consumer accepts pix_data when pix_valid and pix_ready.
- busy  output  1  high from accepted start until frame_done.
- frame_done  output  1  one-cycle pulse when last pixel of frame is popped.

Behaviour:
- Reset values: read_address=BASE_ADDR, read_enable=0, pix_valid=0, pix_data=0, busy=0, frame_done=0; FIFO empty; all counters 0; state IDLE.
- States:
  - IDLE: on start go to ISSUE; busy=1; req_cnt=0; read_address=BASE_ADDR.
  - ISSUE: read_enable=1 while credit = FIFO_DEPTH - (fifo_count + outstanding) > 0.
  - DRAIN: read_enable=0; wait until pop_cnt == FRAME_PIXELS, then pulse frame_done, clear busy, return to IDLE.
- Request acceptance: accepted = read_enable & ~wait_request.
  - On acceptance: read_address += 1, req_cnt += 1, outstanding += 1.
  - When req_cnt reaches FRAME_PIXELS, go to DRAIN.
- Stall: while wait_request=1, read_address and read_enable hold stable. read_enable is never dropped mid-request.
- Return: read_data_valid pushes read_data into the FIFO and decrements outstanding.
  - Acceptance and return in the same cycle: outstanding unchanged.
- Credit is computed from registered counts. fifo_count + outstanding never exceeds FIFO_DEPTH, so a push never finds the FIFO full.
- Pop: pix_valid & pix_ready pops the FIFO and increments pop_cnt.
  - Push and pop in the same cycle on a full or empty FIFO are both legal; count is unchanged.
  - pix_data is FIFO head data, registered, with zero added latency after push.
- Latency: first read_enable the cycle after start. First pix_valid the cycle after the first read_data_valid.
- Ignored inputs:
  - start while busy.
  - read_data_valid when outstanding=0.
- Address arithmetic: 32-bit, wraps modulo 2^32.
- Reset mid-frame: all state cleared immediately. In-flight returns arriving after reset deasserts are discarded (outstanding=0).
- frame_done and IDLE entry occur in the same cycle the final pop occurs.

Optional Feature:
- Macro: MEM_READER_UNDERRUN_EN.
- Defined:
  - Adds output underrun_cnt[15:0]; reset 0.
  - Increments, saturating at 16'hFFFF, each cycle busy & pix_ready & ~pix_valid.
  - Cleared on accepted start.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package julia_mem_pkg:
  - typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} rd_state_t.
  - localparam PIXEL_W=8.
  - localparam ADDR_W=32.
- Sub-module pixel_fifo (parameters DEPTH, WIDTH): synchronous FIFO with push, pop, count, empty and full outputs, using the same clk/rst.

Test Plan:
- FRAME_PIXELS=4, BASE_ADDR=32'h100, wait_request=0, data returned 2 cycles after each request, pix_ready=1 -> addresses 0x100..0x103 issued on consecutive cycles; pixels delivered in order; frame_done pulse on the 4th pop; busy=0 the following cycle.
- wait_request high 3 cycles on the 2nd request -> read_address=0x101 and read_enable=1 held stable throughout; exactly 4 accepted requests total.
- FIFO_DEPTH=4, FRAME_PIXELS=10, pix_ready=0 -> requests stop after 4 accepted; fifo_count=4; no overflow. Raising pix_ready resumes issue; all 10 pixels delivered.
- Push and pop in the same cycle with FIFO_DEPTH=4 full -> count stays 4; head advances; no data loss.
- rst asserted with 2 reads outstanding, 2 late read_data_valid after release -> outputs at reset values; FIFO stays empty; next start fetches from BASE_ADDR.
- With MEM_READER_UNDERRUN_EN: pix_ready=1 and returns delayed 5 cycles -> underrun_cnt=5 at first pix_valid; cleared by the next start.

Source files
------------

// File: rtl/julia_mem_pkg.sv
// Shared types and widths for the Julia framebuffer read path.
package julia_mem_pkg;

    localparam int PIXEL_W = 8;
    localparam int ADDR_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } rd_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous pixel FIFO; the head entry is driven straight from the storage registers,
// so data pushed on one edge is presented on pop_data right after that edge.
module pixel_fifo
    import julia_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = PIXEL_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic [$clog2(DEPTH + 1)-1:0]   count,
    output logic                           empty,
    output logic                           full
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal when a pop frees the head in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_reader.sv
// Pipelined Avalon-MM read master fetching one frame of pixels into a FIFO-backed stream.
// Optional MEM_READER_UNDERRUN_EN adds a saturating starvation counter (underrun_cnt).
module mem_reader
    import julia_mem_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned       FRAME_PIXELS = 307200,
    parameter int unsigned       FIFO_DEPTH   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                wait_request,
    input  logic [PIXEL_W-1:0]  read_data,
    input  logic                read_data_valid,
    output logic [ADDR_W-1:0]   read_address,
    output logic                read_enable,
    output logic [PIXEL_W-1:0]  pix_data,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic                busy,
    output logic                frame_done
`ifdef MEM_READER_UNDERRUN_EN
    ,
    output logic [15:0]         underrun_cnt
`endif
);
    localparam int unsigned        CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned        FRAME_W    = $clog2(FRAME_PIXELS + 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_PIXELS - 1);
    localparam logic [CNT_W:0]     DEPTH_OCC  = (CNT_W + 1)'(FIFO_DEPTH);

    rd_state_t          state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [FRAME_W-1:0] req_cnt_q, pop_cnt_q;
    logic [CNT_W-1:0]   outstanding_q, fifo_count;
    logic [CNT_W:0]     occupancy;
    logic               fifo_empty, fifo_full;
    logic               start_ok, accepted, push, pop, credit_ok;

    // Credit uses registered counts only, so read_enable cannot drop while stalled:
    // during a stall occupancy can only shrink.
    assign occupancy    = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign credit_ok    = ~fifo_full & (occupancy < DEPTH_OCC);
    assign read_enable  = (state_q == ISSUE) & credit_ok;
    assign read_address = addr_q;
    assign accepted     = read_enable & ~wait_request;
    assign push         = read_data_valid & (outstanding_q != '0);
    assign pix_valid    = ~fifo_empty;
    assign pop          = pix_valid & pix_ready;
    assign busy         = (state_q != IDLE);
    assign start_ok     = (state_q == IDLE) & start;

    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = ISSUE;
            end
            ISSUE: begin
                if (accepted && req_cnt_q == FRAME_LAST) state_d = DRAIN;
            end
            DRAIN: begin
                if (pop && pop_cnt_q == FRAME_LAST) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= BASE_ADDR;
            req_cnt_q     <= '0;
            pop_cnt_q     <= '0;
            outstanding_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                addr_q    <= BASE_ADDR;
                req_cnt_q <= '0;
                pop_cnt_q <= '0;
            end else begin
                if (accepted) begin
                    addr_q    <= addr_q + ADDR_W'(1);
                    req_cnt_q <= req_cnt_q + FRAME_W'(1);
                end
                if (pop && busy) begin
                    pop_cnt_q <= pop_cnt_q + FRAME_W'(1);
                end
            end
            case ({accepted, push})
                2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
                2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIXEL_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (read_data),
        .pop       (pop),
        .pop_data  (pix_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

`ifdef MEM_READER_UNDERRUN_EN
    logic [15:0] underrun_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_q <= '0;
        end else if (start_ok) begin
            underrun_q <= '0;
        end else if (busy && pix_ready && !pix_valid && underrun_q != 16'hFFFF) begin
            underrun_q <= underrun_q + 16'd1;
        end
    end

    assign underrun_cnt = underrun_q;
`endif

endmodule

// File: tb/tb_mem_reader.sv
// Directed bench for mem_reader: memory responder model, in-order pixel checks, stall,
// back-pressure, mid-frame reset and (with MEM_READER_UNDERRUN_EN) the starvation counter.
`timescale 1ns/1ps
module tb_mem_reader;

    localparam logic [31:0] BASE  = 32'h100;
    localparam int          FRAME = 10;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        wait_request = 1'b0;
    logic [7:0]  read_data = 8'h00;
    logic        read_data_valid = 1'b0;
    logic        pix_ready = 1'b0;
    logic [31:0] read_address;
    logic        read_enable;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        busy;
    logic        frame_done;
`ifdef MEM_READER_UNDERRUN_EN
    logic [15:0] underrun_cnt;
`endif

    mem_reader #(
        .BASE_ADDR    (BASE),
        .FRAME_PIXELS (FRAME),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .wait_request    (wait_request),
        .read_data       (read_data),
        .read_data_valid (read_data_valid),
        .read_address    (read_address),
        .read_enable     (read_enable),
        .pix_data        (pix_data),
        .pix_valid       (pix_valid),
        .pix_ready       (pix_ready),
        .busy            (busy),
        .frame_done      (frame_done)
`ifdef MEM_READER_UNDERRUN_EN
        ,
        .underrun_cnt    (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix_of(input logic [31:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    typedef struct {
        int         due;
        logic [7:0] data;
    } ret_t;

    ret_t rq[$];
    int   lat        = 2;
    int   edge_n     = 0;
    int   n_acc      = 0;
    int   exp_pop    = 0;
    bit   frame_seen = 1'b0;

    // Runs 1ns before each rising edge: sees exactly what the DUT samples.
    task automatic sample_slot();
        ret_t r;
        #4;
        if (read_enable && !wait_request && !rst) begin
            check("req_addr", read_address, BASE + n_acc);
            r.due  = edge_n + 1 + lat;
            r.data = pix_of(read_address);
            rq.push_back(r);
            n_acc++;
        end
        if (pix_valid && pix_ready && !rst) begin
            check("pix_data", pix_data, pix_of(BASE + exp_pop));
            exp_pop++;
            check("done_at_pop", frame_done, exp_pop == FRAME);
            if (frame_done) frame_seen = 1'b1;
        end else if (frame_done) begin
            check("done_without_pop", frame_done, 1'b0);
        end
    endtask

    // Falling edge: drive the memory return for the next rising edge.
    task automatic drive_returns();
        ret_t r;
        @(negedge clk);
        edge_n++;
        if (rq.size() > 0 && rq[0].due <= edge_n + 1) begin
            r               = rq.pop_front();
            read_data_valid = 1'b1;
            read_data       = r.data;
        end else begin
            read_data_valid = 1'b0;
            read_data       = 8'h00;
        end
    endtask

    task automatic tick();
        sample_slot();
        drive_returns();
    endtask

    task automatic begin_frame();
        n_acc      = 0;
        exp_pop    = 0;
        frame_seen = 1'b0;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_frame(input int budget);
        for (int i = 0; i < budget && !frame_seen; i++) tick();
        check("frame_done_seen", frame_seen, 1'b1);
    endtask

    initial begin
        tick();
        tick();
        check("rst_addr", read_address, BASE);
        check("rst_re", read_enable, 1'b0);
        check("rst_pix_valid", pix_valid, 1'b0);
        check("rst_pix_data", pix_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        rst = 1'b0;
        tick();

        // Frame with a 3-cycle stall on the second request.
        pix_ready = 1'b1;
        lat       = 2;
        begin_frame();
        check("busy_after_start", busy, 1'b1);
        check("first_re", read_enable, 1'b1);
        check("first_addr", read_address, BASE);
        tick();
        wait_request = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("stall_addr", read_address, BASE + 1);
            check("stall_re", read_enable, 1'b1);
            tick();
        end
        wait_request = 1'b0;
        wait_frame(200);
        check("stall_acc_total", n_acc, FRAME);
        check("busy_after_done", busy, 1'b0);
        check("re_after_done", read_enable, 1'b0);

        // Back-pressure: issue stops once FIFO plus outstanding reach DEPTH.
        pix_ready = 1'b0;
        begin_frame();
        repeat (20) tick();
        check("bp_acc", n_acc, DEPTH);
        check("bp_re", read_enable, 1'b0);
        check("bp_pix_valid", pix_valid, 1'b1);
        check("bp_head", pix_data, pix_of(BASE));
        check("bp_busy", busy, 1'b1);
        pix_ready = 1'b1;
        tick();
        pix_ready = 1'b0;
        check("head_advance", pix_data, pix_of(BASE + 1));
        repeat (6) tick();
        check("refill_acc", n_acc, DEPTH + 1);
        check("refill_re", read_enable, 1'b0);
        pix_ready = 1'b1;
        wait_frame(200);
        check("bp_acc_total", n_acc, FRAME);
        check("bp_busy_after", busy, 1'b0);

        // Reset with two reads outstanding; their late returns must be dropped.
        lat       = 6;
        pix_ready = 1'b0;
        begin_frame();
        tick();
        tick();
        check("inflight_acc", n_acc, 2);
        rst = 1'b1;
        sample_slot();
        check("async_rst_addr", read_address, BASE);
        check("async_rst_re", read_enable, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        drive_returns();
        tick();
        rst = 1'b0;
        repeat (8) tick();
        check("late_pix_valid", pix_valid, 1'b0);
        check("late_pix_data", pix_data, 8'h00);
        check("late_busy", busy, 1'b0);
        check("late_re", read_enable, 1'b0);
        check("late_addr", read_address, BASE);

        lat       = 2;
        pix_ready = 1'b1;
        begin_frame();
        check("restart_addr", read_address, BASE);
        check("restart_re", read_enable, 1'b1);
        wait_frame(200);
        check("restart_acc_total", n_acc, FRAME);
        check("restart_busy_after", busy, 1'b0);

`ifdef MEM_READER_UNDERRUN_EN
        // Returns land 4 edges after acceptance: 5 starved cycles before first pix_valid.
        lat = 4;
        begin_frame();
        check("underrun_cleared", underrun_cnt, 16'd0);
        for (int i = 0; i < 20 && !pix_valid; i++) tick();
        check("underrun_first_valid", underrun_cnt, 16'd5);
        wait_frame(200);
        lat = 2;
        begin_frame();
        check("underrun_restart_clear", underrun_cnt, 16'd0);
        wait_frame(200);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
